// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, sync polarity encodings and
// the registered control bundle shared by the VGA sync path.
package vga_timing_pkg;

  localparam int unsigned H_DISP  = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_DISP  = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Sync and blanking levels, registered together so they stay aligned with x/y.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_ctl_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: turns the upstream divided-clock toggle into a one-clk pixel
// tick. div_clk is treated as data sampled on clk, never as a clock.
module pix_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic div_clk,
  output logic tick
);

  localparam int unsigned      PRE_W   = cnt_width(PIX_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PIX_DIV - 1);

  logic             div_q;
  logic             rise;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  assign rise = div_clk & ~div_q;

  // Sample div_clk and hold the prescaler count.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 1'b0;
      pre_q <= '0;
    end else begin
      div_q <= div_clk;
      pre_q <= pre_d;
    end
  end

  // Count rise events; the PIX_DIV-th rise fires the tick and wraps the count.
  // With PIX_DIV=1 the count is pinned at zero, so every rise is a tick.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (rise) begin
      if (pre_q == PRE_MAX) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing. Holds the x/y pixel counters, advanced by
// the pixel tick, and decodes hsync, vsync and video_on from them.
module vga_sync_gen #(
  parameter int unsigned H_DISP   = vga_timing_pkg::H_DISP,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_DISP   = vga_timing_pkg::V_DISP,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  output logic             pixel_tick,
  output logic             frame_start,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISP + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0) ? vga_timing_pkg::SYNC_ACTIVE_HIGH
                                             : vga_timing_pkg::SYNC_ACTIVE_LOW;

  logic                     tick;
  logic [CNT_W-1:0]         x_q;
  logic [CNT_W-1:0]         x_d;
  logic [CNT_W-1:0]         y_q;
  logic [CNT_W-1:0]         y_d;
  vga_timing_pkg::vga_ctl_t ctl_q;
  vga_timing_pkg::vga_ctl_t ctl_d;
  logic                     pixel_tick_q;
  logic                     frame_start_q;
  logic                     frame_start_d;

  pix_tick_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .div_clk (div_clk),
    .tick    (tick)
  );

  // Next raster position: x steps on each tick, y steps when x wraps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Decode from the next-state position so the registered syncs land in the
  // same clk as the x/y they describe.
  always_comb begin
    ctl_d          = '0;
    ctl_d.hsync    = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_ON : ~SYNC_ON;
    ctl_d.vsync    = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_ON : ~SYNC_ON;
    ctl_d.video_on = (x_d < H_VIS) && (y_d < V_VIS);
    frame_start_d  = tick && (x_d == '0) && (y_d == '0);
  end

  // Raster state and registered outputs; reset parks syncs inactive and blanks video.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      ctl_q.hsync    <= ~SYNC_ON;
      ctl_q.vsync    <= ~SYNC_ON;
      ctl_q.video_on <= 1'b0;
      pixel_tick_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      ctl_q          <= ctl_d;
      pixel_tick_q   <= tick;
      frame_start_q  <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = ctl_q.hsync;
  assign vsync       = ctl_q.vsync;
  assign video_on    = ctl_q.video_on;
  assign pixel_tick  = pixel_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three instances (VGA defaults; PIX_DIV=1 active-high tiny
// raster; PIX_DIV=3 active-low tiny raster). Stimulus queues the expected
// position/levels of every pixel tick; a negedge monitor pops and compares.
module tb_vga_sync_gen;

  typedef struct {
    int cyc;
    int x;
    int y;
    bit hs;
    bit vs;
    bit vo;
    bit fs;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v = '1;
  logic [2:0] div_v = '0;

  logic       pt_a, fs_a, hs_a, vs_a, vo_a;
  logic [9:0] x_a, y_a;
  logic       pt_b, fs_b, hs_b, vs_b, vo_b;
  logic [3:0] x_b, y_b;
  logic       pt_c, fs_c, hs_c, vs_c, vo_c;
  logic [3:0] x_c, y_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_low0 = 0;

  // Hand-derived timing per instance: totals, sync windows [lo,hi), visible area.
  int    HT  [3] = '{800, 14, 12};
  int    VT  [3] = '{525, 7, 7};
  int    HSL [3] = '{656, 10, 7};
  int    HSH [3] = '{752, 12, 10};
  int    VSL [3] = '{490, 5, 5};
  int    VSH [3] = '{492, 6, 6};
  int    HD  [3] = '{640, 8, 6};
  int    VD  [3] = '{480, 4, 3};
  int    PD  [3] = '{2, 1, 3};
  int    POL [3] = '{0, 1, 0};
  string DN  [3] = '{"A", "B", "C"};

  int n      [3] = '{0, 0, 0};
  int rises  [3] = '{0, 0, 0};
  bit prev   [3] = '{0, 0, 0};
  int frames [3] = '{0, 0, 0};

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_v[0]), .div_clk(div_v[0]),
    .pixel_tick(pt_a), .frame_start(fs_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a)
  );

  vga_sync_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(1), .SYNC_POL(1), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(rst_v[1]), .div_clk(div_v[1]),
    .pixel_tick(pt_b), .frame_start(fs_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b)
  );

  vga_sync_gen #(
    .H_DISP(6), .H_FP(1), .H_SYNC(3), .H_BP(2),
    .V_DISP(3), .V_FP(2), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(3), .SYNC_POL(0), .CNT_W(4)
  ) dut_c (
    .clk(clk), .reset(rst_v[2]), .div_clk(div_v[2]),
    .pixel_tick(pt_c), .frame_start(fs_c), .x(x_c), .y(y_c),
    .hsync(hs_c), .vsync(vs_c), .video_on(vo_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int d, input int nn, input int c);
    exp_t e;
    bit   act;
    e.cyc = c;
    e.x   = nn % HT[d];
    e.y   = (nn / HT[d]) % VT[d];
    act   = (e.x >= HSL[d]) && (e.x < HSH[d]);
    e.hs  = (POL[d] != 0) ? act : !act;
    act   = (e.y >= VSL[d]) && (e.y < VSH[d]);
    e.vs  = (POL[d] != 0) ? act : !act;
    e.vo  = (e.x < HD[d]) && (e.y < VD[d]);
    e.fs  = (e.x == 0) && (e.y == 0);
    return e;
  endfunction

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Drive one clk of div_clk; a completed pixel queues its expectation for the coming edge.
  task automatic step(input int d, input bit v);
    div_v[d] = v;
    if (v && !prev[d]) begin
      rises[d]++;
      if (rises[d] == PD[d]) begin
        rises[d] = 0;
        n[d]++;
        push(d, model(d, n[d], cyc + 1));
      end
    end
    prev[d] = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int d, output int ox, output int oy, output bit ohs,
                        output bit ovs, output bit ovo, output bit opt, output bit ofs);
    case (d)
      0: begin ox = int'(x_a); oy = int'(y_a); ohs = hs_a; ovs = vs_a; ovo = vo_a; opt = pt_a; ofs = fs_a; end
      1: begin ox = int'(x_b); oy = int'(y_b); ohs = hs_b; ovs = vs_b; ovo = vo_b; opt = pt_b; ofs = fs_b; end
      default: begin ox = int'(x_c); oy = int'(y_c); ohs = hs_c; ovs = vs_c; ovo = vo_c; opt = pt_c; ofs = fs_c; end
    endcase
  endtask

  // Assert reset with div_clk still toggling, check the parked state, then release.
  task automatic do_reset(input int d, input int ncyc);
    int sx, sy;
    bit shs, svs, svo, spt, sfs;
    bit inact;
    inact = (POL[d] != 0) ? 1'b0 : 1'b1;
    rst_v[d] = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      div_v[d] = ~div_v[d];
      @(posedge clk);
      #1;
      if (i == 0) begin
        sample(d, sx, sy, shs, svs, svo, spt, sfs);
        chk({DN[d], " reset x"}, sx, 0);
        chk({DN[d], " reset y"}, sy, 0);
        chk({DN[d], " reset hsync"}, shs, inact);
        chk({DN[d], " reset vsync"}, svs, inact);
        chk({DN[d], " reset video_on"}, svo, 0);
        chk({DN[d], " reset pixel_tick"}, spt, 0);
        chk({DN[d], " reset frame_start"}, sfs, 0);
      end
    end
    rst_v[d] = 1'b0;
    div_v[d] = 1'b0;
    prev[d]  = 1'b0;
    rises[d] = 0;
    n[d]     = 0;
    @(posedge clk);
    #1;
    sample(d, sx, sy, shs, svs, svo, spt, sfs);
    chk({DN[d], " release x"}, sx, 0);
    chk({DN[d], " release y"}, sy, 0);
    chk({DN[d], " release hsync"}, shs, inact);
    chk({DN[d], " release vsync"}, svs, inact);
    chk({DN[d], " release video_on"}, svo, 1);
    chk({DN[d], " release pixel_tick"}, spt, 0);
  endtask

  task automatic mon(input int d, input bit pt, input bit fs, input int ax, input int ay,
                     input bit hs, input bit vs, input bit vo);
    exp_t e;
    if (pt) begin
      if (qsize(d) == 0) begin
        chk({DN[d], " unexpected pixel_tick"}, 1, 0);
      end else begin
        e = qpop(d);
        chk({DN[d], " tick cycle"}, cyc, e.cyc);
        chk({DN[d], " x"}, ax, e.x);
        chk({DN[d], " y"}, ay, e.y);
        chk({DN[d], " hsync"}, hs, e.hs);
        chk({DN[d], " vsync"}, vs, e.vs);
        chk({DN[d], " video_on"}, vo, e.vo);
        chk({DN[d], " frame_start"}, fs, e.fs);
        if (d == 0 && e.y == 0 && hs == 1'b0) hs_low0++;
        if (fs) frames[d]++;
      end
    end else if (fs) begin
      chk({DN[d], " frame_start without pixel_tick"}, 1, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, pt_a, fs_a, int'(x_a), int'(y_a), hs_a, vs_a, vo_a);
    mon(1, pt_b, fs_b, int'(x_b), int'(y_b), hs_b, vs_b, vo_b);
    mon(2, pt_c, fs_c, int'(x_c), int'(y_c), hs_c, vs_c, vo_c);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not complete, got %0d checks expected completion", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   sx, sy;
    bit   shs, svs, svo, spt, sfs;
    int   hold [5] = '{1, 2, 3, 1, 4};
    int   k = 0;
    bit   v = 1'b0;
    exp_t e;
    @(posedge clk);
    #1;
    fork
      begin : run_a
        do_reset(0, 3);
        while (n[0] < 700) step(0, ~div_v[0]);
        repeat (50) step(0, 1'b1);
        sample(0, sx, sy, shs, svs, svo, spt, sfs);
        e = model(0, n[0], 0);
        chk("A freeze x", sx, 700);
        chk("A freeze y", sy, 0);
        chk("A freeze hsync", shs, e.hs);
        while (n[0] < 1100) step(0, ~div_v[0]);
        do_reset(0, 4);
        while (n[0] < 20) step(0, ~div_v[0]);
      end
      begin : run_b
        do_reset(1, 3);
        while (n[1] < 250) step(1, ~div_v[1]);
        chk("B frame_start count before reset", frames[1], 2);
        do_reset(1, 2);
        while (n[1] < 100) step(1, ~div_v[1]);
      end
      begin : run_c
        do_reset(2, 3);
        while (n[2] < 200) begin
          v = ~v;
          repeat (hold[k % 5]) step(2, v);
          k++;
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("A expected ticks outstanding", qsize(0), 0);
    chk("B expected ticks outstanding", qsize(1), 0);
    chk("C expected ticks outstanding", qsize(2), 0);
    chk("A hsync low pixels on line 0", hs_low0, 96);
    chk("B frame_start total", frames[1], 3);
    chk("C frame_start total", frames[2], 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
